frame_rasterizer: RTL and testbench

// Producer end of the double-buffered VGA framebuffer write port (write_x/write_y/write_palette, clk_33m domain).

---
 rtl/frame_rasterizer.sv | 200 ++++++++++++++++++++
 tb/tb_frame_rasterizer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_rasterizer.sv
// Framebuffer write-port producer: per refresh frame, optionally clears the write half, then rasterizes
// clipped solid rectangles from a valid/ready command stream, one pixel per cycle.
// Build option: define FRAMERAST_CLEAR_EN to include the background clear pass.
module frame_rasterizer #(
  parameter int COOR_WIDTH = 12,
  parameter int FRAME_W    = 1280,
  parameter int FRAME_H    = 300,
  parameter int BG_PALETTE = 1
) (
  input  logic                  clk_33m,
  input  logic                  rst_33m,
  input  logic                  rst_screen_33m,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [COOR_WIDTH-1:0] cmd_x0,
  input  logic [COOR_WIDTH-1:0] cmd_y0,
  input  logic [COOR_WIDTH-1:0] cmd_w,
  input  logic [COOR_WIDTH-1:0] cmd_h,
  input  logic [1:0]            cmd_palette,
  input  logic                  cmd_last,
  output logic [COOR_WIDTH-1:0] write_x,
  output logic [COOR_WIDTH-1:0] write_y,
  output logic [1:0]            write_palette,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  // state   | meaning
  // S_IDLE  | waiting for the falling edge of the refresh pulse
  // S_CLEAR | painting the whole frame with BG_PALETTE
  // S_FETCH | offering cmd_ready, accepting one command
  // S_DRAW  | rasterizing the latched, clipped rectangle
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FETCH, S_DRAW} state_t;

  localparam int CW = COOR_WIDTH + 1;
  localparam logic [CW-1:0] FW = CW'(FRAME_W);
  localparam logic [CW-1:0] FH = CW'(FRAME_H);
  localparam logic [1:0]    BG = 2'(BG_PALETTE);

  state_t state, state_next;

  logic                  screen_prev;
  logic                  start, rise, hs;
  logic                  cmd_empty;
  logic [CW-1:0]         x_sum, y_sum, x_clip, y_clip;
  logic [COOR_WIDTH-1:0] cx, cy;
  logic [COOR_WIDTH-1:0] x_start_q;
  logic [CW-1:0]         x_end_q, y_end_q;
  logic [1:0]            pal_q;
  logic                  last_q;
  logic [COOR_WIDTH-1:0] row_start;
  logic [CW-1:0]         row_end, col_end;
  logic [CW-1:0]         cx_inc, cy_inc;
  logic                  row_last, col_last;
  logic                  emit, load, clear_entry;
  logic                  done_next, over_next, ready_next;

  assign start = screen_prev && !rst_screen_33m;
  assign rise  = !screen_prev && rst_screen_33m;
  assign hs    = cmd_valid && cmd_ready;
  assign busy  = (state != S_IDLE);

  // Sums carry one extra bit so x0+w can never wrap before clipping.
  assign x_sum  = {1'b0, cmd_x0} + {1'b0, cmd_w};
  assign y_sum  = {1'b0, cmd_y0} + {1'b0, cmd_h};
  assign x_clip = (x_sum > FW) ? FW : x_sum;
  assign y_clip = (y_sum > FH) ? FH : y_sum;

  assign cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                     ({1'b0, cmd_x0} >= FW) || ({1'b0, cmd_y0} >= FH) ||
                     (cmd_palette == 2'd0);

  assign row_start = (state == S_CLEAR) ? '0 : x_start_q;
  assign row_end   = (state == S_CLEAR) ? FW : x_end_q;
  assign col_end   = (state == S_CLEAR) ? FH : y_end_q;
  assign cx_inc    = {1'b0, cx} + CW'(1);
  assign cy_inc    = {1'b0, cy} + CW'(1);
  assign row_last  = (cx_inc == row_end);
  assign col_last  = (cy_inc == col_end);

  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    load        = 1'b0;
    clear_entry = 1'b0;
    done_next   = 1'b0;
    over_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef FRAMERAST_CLEAR_EN
          state_next  = S_CLEAR;
          clear_entry = 1'b1;
`else
          state_next  = S_FETCH;
`endif
        end
      end
`ifdef FRAMERAST_CLEAR_EN
      S_CLEAR: begin
        emit = 1'b1;
        if (row_last && col_last) state_next = S_FETCH;
      end
`endif
      S_FETCH: begin
        if (hs) begin
          if (cmd_empty) begin
            if (cmd_last) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            load       = 1'b1;
            state_next = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        emit = 1'b1;
        if (row_last && col_last) begin
          if (last_q) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A new refresh before the frame finished wins over everything in flight.
    if (rise && (state != S_IDLE)) begin
      state_next  = S_IDLE;
      emit        = 1'b0;
      load        = 1'b0;
      clear_entry = 1'b0;
      done_next   = 1'b0;
      over_next   = 1'b1;
    end
  end

  // Ready is registered and drops for one cycle after every handshake.
  assign ready_next = (state_next == S_FETCH) && !hs;

  always_ff @(posedge clk_33m) begin
    if (rst_33m) begin
      state         <= S_IDLE;
      screen_prev   <= 1'b0;
      cmd_ready     <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      write_x       <= '0;
      write_y       <= '0;
      write_palette <= 2'd0;
      cx            <= '0;
      cy            <= '0;
      x_start_q     <= '0;
      x_end_q       <= '0;
      y_end_q       <= '0;
      pal_q         <= 2'd0;
      last_q        <= 1'b0;
    end else begin
      state       <= state_next;
      screen_prev <= rst_screen_33m;
      cmd_ready   <= ready_next;
      frame_done  <= done_next;
      overrun     <= over_next;

      if (emit) begin
        write_x       <= cx;
        write_y       <= cy;
        write_palette <= (state == S_CLEAR) ? BG : pal_q;
      end else begin
        write_palette <= 2'd0;
      end

      if (clear_entry) begin
        cx <= '0;
        cy <= '0;
      end else if (load) begin
        cx        <= cmd_x0;
        cy        <= cmd_y0;
        x_start_q <= cmd_x0;
        x_end_q   <= x_clip;
        y_end_q   <= y_clip;
        pal_q     <= cmd_palette;
        last_q    <= cmd_last;
      end else if (emit) begin
        if (row_last) begin
          cx <= row_start;
          cy <= cy_inc[COOR_WIDTH-1:0];
        end else begin
          cx <= cx_inc[COOR_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_rasterizer.sv
// Scoreboard bench for frame_rasterizer on an 8x4 frame: directed frames plus randomized command streams.
// Follows FRAMERAST_CLEAR_EN the same way as the design so both builds are modelled.
module tb_frame_rasterizer;
  localparam int CW = 12;
  localparam int FW = 8;
  localparam int FH = 4;
  localparam int BGP = 1;

  logic          clk_33m = 1'b0;
  logic          rst_33m = 1'b1;
  logic          rst_screen_33m = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [1:0]    cmd_palette = 2'd0;
  logic          cmd_last = 1'b0;
  logic [CW-1:0] write_x, write_y;
  logic [1:0]    write_palette;
  logic          busy, frame_done, overrun;

  frame_rasterizer #(.COOR_WIDTH(CW), .FRAME_W(FW), .FRAME_H(FH), .BG_PALETTE(BGP)) dut (
    .clk_33m(clk_33m), .rst_33m(rst_33m), .rst_screen_33m(rst_screen_33m),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_palette(cmd_palette), .cmd_last(cmd_last),
    .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
    .busy(busy), .frame_done(frame_done), .overrun(overrun));

  always #5 clk_33m = ~clk_33m;

  typedef struct {int x; int y; int p;} pix_t;
  pix_t exp_q[$];
  pix_t exp_pix;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, exp_done = 0;
  int over_cnt = 0, exp_over = 0;

  // Reference: a rectangle is the set of in-frame pixels in row-major order; palette 0 draws nothing.
  task automatic push_rect(input int x0, input int y0, input int w, input int h, input int pal);
    int xe, ye;
    if (pal == 0) return;
    xe = (x0 + w < FW) ? x0 + w : FW;
    ye = (y0 + h < FH) ? y0 + h : FH;
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++)
        exp_q.push_back('{x, y, pal});
  endtask

  // Monitor: compares every emitted pixel against the head of the expected queue.
  always @(negedge clk_33m) begin
    if (!rst_33m) begin
      if (frame_done === 1'b1) done_cnt++;
      if (overrun === 1'b1) begin
        over_cnt++;
        checks++;
        if (write_palette !== 2'd0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_outputs palette=%0d busy=%0b want palette=0 busy=0", write_palette, busy);
        end
        exp_q.delete();
      end else if (write_palette !== 2'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write got (%0d,%0d) pal=%0d, no write expected", write_x, write_y, write_palette);
        end else begin
          exp_pix = exp_q.pop_front();
          if (write_x !== CW'(exp_pix.x) || write_y !== CW'(exp_pix.y) || write_palette !== 2'(exp_pix.p)) begin
            errors++;
            $display("FAIL pixel got (%0d,%0d) pal=%0d want (%0d,%0d) pal=%0d",
                     write_x, write_y, write_palette, exp_pix.x, exp_pix.y, exp_pix.p);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0b want %0b", name, got, want);
    end
  endtask

  task automatic pulse_screen(input int len);
    @(posedge clk_33m); #1 rst_screen_33m = 1'b1;
    repeat (len) @(posedge clk_33m);
`ifdef FRAMERAST_CLEAR_EN
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        exp_q.push_back('{x, y, BGP});
`endif
    #1 rst_screen_33m = 1'b0;
    @(posedge clk_33m); #1;
    check1("start_busy", busy, 1'b1);
`ifdef FRAMERAST_CLEAR_EN
    check1("start_ready_clear", cmd_ready, 1'b0);
`else
    check1("start_ready_noclear", cmd_ready, 1'b1);
`endif
  endtask

  task automatic send_cmd(input int x0, input int y0, input int w, input int h, input int pal, input bit last);
    int t = 0;
    @(negedge clk_33m);
    while (cmd_ready !== 1'b1 && t < 300) begin
      @(negedge clk_33m);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL cmd_ready_timeout got 0 want 1 within 300 cycles");
      return;
    end
    cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_w = CW'(w); cmd_h = CW'(h);
    cmd_palette = 2'(pal); cmd_last = last; cmd_valid = 1'b1;
    push_rect(x0, y0, w, h, pal);
    @(posedge clk_33m); #1 cmd_valid = 1'b0;
  endtask

  task automatic end_frame();
    int t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(posedge clk_33m); #1;
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b want 0", busy);
    end
    exp_done++;
    repeat (3) @(posedge clk_33m);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL frame_done_count got %0d want %0d", done_cnt, exp_done);
    end
    checks++;
    if (over_cnt != exp_over) begin
      errors++;
      $display("FAIL overrun_count got %0d want %0d", over_cnt, exp_over);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk_33m);
    #1 rst_33m = 1'b0;
    @(negedge clk_33m);
    checks++;
    if (write_x !== '0 || write_y !== '0 || write_palette !== 2'd0) begin
      errors++;
      $display("FAIL reset_write got (%0d,%0d) pal=%0d want (0,0) pal=0", write_x, write_y, write_palette);
    end
    check1("reset_ready", cmd_ready, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", frame_done, 1'b0);
    check1("reset_overrun", overrun, 1'b0);

    pulse_screen(3);
    send_cmd(2, 1, 3, 2, 2, 1'b1);
    end_frame();

    pulse_screen(3);
    send_cmd(6, 3, 5, 4, 3, 1'b1);
    end_frame();

    pulse_screen(3);
    send_cmd(1, 1, 0, 2, 2, 1'b0);
    send_cmd(9, 0, 2, 2, 3, 1'b0);
    send_cmd(0, 0, 3, 3, 0, 1'b1);
    end_frame();

    // Refresh arrives mid-rectangle: abort, then the same pulse restarts a fresh frame.
    pulse_screen(2);
    send_cmd(0, 0, 8, 4, 2, 1'b1);
    repeat (4) @(posedge clk_33m);
    exp_over++;
    pulse_screen(3);
    send_cmd(3, 0, 2, 4, 3, 1'b1);
    end_frame();

    for (int f = 0; f < 20; f++) begin
      pulse_screen($urandom_range(1, 4));
      n = $urandom_range(1, 5);
      for (int c = 0; c < n; c++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_33m);
        send_cmd($urandom_range(0, 10), $urandom_range(0, 6), $urandom_range(0, 9),
                 $urandom_range(0, 5), $urandom_range(0, 3), (c == n - 1));
      end
      end_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
